imem_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_ram.sv | 39 +++
 rtl/imem_responder.sv | 117 +++++++++++
 tb/tb_imem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_WIDTH  = 32;
    localparam int unsigned IMEM_INSTR_WIDTH = 32;
    localparam int unsigned IMEM_BE_WIDTH    = 4;

    // addi x0, x0, 0
    localparam logic [IMEM_INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    typedef struct packed {
        logic [IMEM_ADDR_WIDTH-1:0]  addr;
        logic [IMEM_INSTR_WIDTH-1:0] data;
        logic [IMEM_BE_WIDTH-1:0]    be;
    } ld_req_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with byte enables; read data holds between reads.
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en,
    input  logic                        we,
    input  logic [IMEM_BE_WIDTH-1:0]    be,
    input  logic [IDX_W-1:0]            addr,
    input  logic [IMEM_INSTR_WIDTH-1:0] wdata,
    output logic [IMEM_INSTR_WIDTH-1:0] rdata
);

    logic [IMEM_INSTR_WIDTH-1:0] mem [DEPTH_WORDS];

    // Storage is never reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (en && we && !rst_i) begin
            for (int b = 0; b < int'(IMEM_BE_WIDTH); b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= NOP_INSTR;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory slave with a host load port and LOAD/RUN control.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned               DEPTH_WORDS = 1024,
    parameter logic [IMEM_ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned               ADDR_WIDTH  = IMEM_ADDR_WIDTH,
    parameter int unsigned               INSTR_WIDTH = IMEM_INSTR_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_WIDTH-1:0]    i_m_addr_i,
    input  logic                     i_m_rden_i,
    output logic                     i_m_hit_o,
    output logic [INSTR_WIDTH-1:0]   i_m_rdata_o,
    input  logic                     ld_valid_i,
    output logic                     ld_ready_o,
    input  logic [ADDR_WIDTH-1:0]    ld_addr_i,
    input  logic [31:0]              ld_data_i,
    input  logic [3:0]               ld_be_i,
    input  logic                     run_i,
    input  logic                     halt_i,
    output logic                     running_o,
    output logic [ADDR_WIDTH-1:0]    ld_count_o,
    output logic                     err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LIM_W = ADDR_WIDTH + 1;
    // One extra bit so the upper bound cannot wrap at the top of the address space.
    localparam logic [LIM_W-1:0] LIMIT =
        LIM_W'(BASE_ADDR) + LIM_W'(64'(DEPTH_WORDS) * 64'd4);

    imem_state_t state;
    ld_req_t     ld_req;

    logic             fetch_ok;
    logic             ld_ok;
    logic             ld_accept;
    logic             ram_en;
    logic             ram_we;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ld_idx;
    logic [IDX_W-1:0] ram_addr;

    assign ld_req = '{addr: IMEM_ADDR_WIDTH'(ld_addr_i), data: ld_data_i, be: ld_be_i};

    // Range and alignment checks use full-width unsigned compares.
    assign fetch_ok = (i_m_addr_i >= ADDR_WIDTH'(BASE_ADDR)) &&
                      (LIM_W'(i_m_addr_i) < LIMIT) &&
                      (i_m_addr_i[1:0] == 2'b00);
    assign ld_ok    = (ADDR_WIDTH'(ld_req.addr) >= ADDR_WIDTH'(BASE_ADDR)) &&
                      (LIM_W'(ld_req.addr) < LIMIT) &&
                      (ld_req.addr[1:0] == 2'b00);

    assign fetch_idx = IDX_W'((i_m_addr_i - ADDR_WIDTH'(BASE_ADDR)) >> 2);
    assign ld_idx    = IDX_W'((ADDR_WIDTH'(ld_req.addr) - ADDR_WIDTH'(BASE_ADDR)) >> 2);

    // A served fetch owns the single RAM port; the load port yields.
    assign i_m_hit_o  = i_m_rden_i && running_o && fetch_ok;
    assign ld_ready_o = !i_m_hit_o;
    assign ld_accept  = ld_valid_i && ld_ready_o;

    assign ram_en   = i_m_hit_o || (ld_accept && ld_ok);
    assign ram_we   = !i_m_hit_o;
    assign ram_addr = i_m_hit_o ? fetch_idx : ld_idx;

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ld_req.be),
        .addr  (ram_addr),
        .wdata (ld_req.data),
        .rdata (i_m_rdata_o)
    );

    // Control FSM plus load counter and sticky fetch error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= LOAD;
            running_o  <= 1'b0;
            ld_count_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (i_m_rden_i && running_o && !fetch_ok) begin
                err_o <= 1'b1;
            end
            if (ld_accept && (ld_count_o != '1)) begin
                ld_count_o <= ld_count_o + ADDR_WIDTH'(1);
            end
            case (state)
                LOAD: begin
                    if (run_i) begin
                        state     <= RUN;
                        running_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt_i) begin
                        state      <= LOAD;
                        running_o  <= 1'b0;
                        ld_count_o <= '0;
                    end
                end
                default: begin
                    state     <= LOAD;
                    running_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder.
module tb_imem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] i_m_addr_i;
    logic          i_m_rden_i;
    logic          i_m_hit_o;
    logic [31:0]   i_m_rdata_o;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [AW-1:0] ld_addr_i;
    logic [31:0]   ld_data_i;
    logic [3:0]    ld_be_i;
    logic          run_i;
    logic          halt_i;
    logic          running_o;
    logic [AW-1:0] ld_count_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_m_addr_i  (i_m_addr_i),
        .i_m_rden_i  (i_m_rden_i),
        .i_m_hit_o   (i_m_hit_o),
        .i_m_rdata_o (i_m_rdata_o),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_addr_i   (ld_addr_i),
        .ld_data_i   (ld_data_i),
        .ld_be_i     (ld_be_i),
        .run_i       (run_i),
        .halt_i      (halt_i),
        .running_o   (running_o),
        .ld_count_o  (ld_count_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ld_valid_i = 1'b1;
        ld_addr_i  = a;
        ld_data_i  = d;
        ld_be_i    = be;
        #1;
        check("ld_ready_write", 32'(ld_ready_o), 32'd1);
        step();
        ld_valid_i = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic exp_hit,
                         input logic [31:0] exp_data);
        i_m_rden_i = 1'b1;
        i_m_addr_i = a;
        #1;
        check({tag, "_hit"}, 32'(i_m_hit_o), 32'(exp_hit));
        step();
        i_m_rden_i = 1'b0;
        check({tag, "_rdata"}, i_m_rdata_o, exp_data);
    endtask

    task automatic pulse_run();
        run_i = 1'b1;
        step();
        run_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        i_m_addr_i = '0; i_m_rden_i = 1'b0;
        ld_valid_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; ld_be_i = '0;
        run_i = 1'b0; halt_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        #1;
        check("rst_running", 32'(running_o), 32'd0);
        check("rst_rdata", i_m_rdata_o, NOP);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_count", ld_count_o, 32'd0);
        check("rst_hit", 32'(i_m_hit_o), 32'd0);

        // Fetches in LOAD always miss and leave the NOP in place
        for (int i = 0; i < 3; i++) fetch("load_miss", 32'h0, 1'b0, NOP);
        check("load_err", 32'(err_o), 32'd0);

        ld_write(32'h0, 32'h0050_0093, 4'hF);
        ld_write(32'h4, 32'h00A0_0113, 4'hF);
        pulse_run();
        check("run_running", 32'(running_o), 32'd1);
        fetch("f0", 32'h0, 1'b1, 32'h0050_0093);
        fetch("f4", 32'h4, 1'b1, 32'h00A0_0113);
        check("count2", ld_count_o, 32'd2);

        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_hit", 32'(i_m_hit_o), 32'd0);
            step();
            check("stall_rdata", i_m_rdata_o, 32'h00A0_0113);
        end

        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        check("halt_running", 32'(running_o), 32'd0);
        check("halt_count", ld_count_o, 32'd0);

        ld_write(32'h8, 32'hFFFF_FFFF, 4'hF);
        ld_write(32'h8, 32'h0000_0000, 4'b0011);
        ld_write(32'hFC, 32'hDEAD_BEEF, 4'hF);
        check("count3", ld_count_o, 32'd3);
        pulse_run();
        fetch("be8", 32'h8, 1'b1, 32'hFFFF_0000);
        fetch("last_word", 32'hFC, 1'b1, 32'hDEAD_BEEF);

        fetch("misalign", 32'h2, 1'b0, 32'hDEAD_BEEF);
        check("err_set", 32'(err_o), 32'd1);
        fetch("past_end", 32'h100, 1'b0, 32'hDEAD_BEEF);
        step(); step();
        check("err_sticky", 32'(err_o), 32'd1);

        // Fetch wins the port: load stalls, memory untouched
        ld_valid_i = 1'b1; ld_addr_i = 32'h0; ld_data_i = 32'h1234_5678; ld_be_i = 4'hF;
        i_m_rden_i = 1'b1; i_m_addr_i = 32'h0;
        #1;
        check("conf_ready", 32'(ld_ready_o), 32'd0);
        check("conf_hit", 32'(i_m_hit_o), 32'd1);
        step();
        i_m_rden_i = 1'b0;
        check("conf_rdata", i_m_rdata_o, 32'h0050_0093);
        check("conf_count", ld_count_o, 32'd3);
        #1;
        check("conf_ready2", 32'(ld_ready_o), 32'd1);
        step();
        ld_valid_i = 1'b0;
        check("conf_count2", ld_count_o, 32'd4);
        fetch("after_wr", 32'h0, 1'b1, 32'h1234_5678);

        ld_write(32'h200, 32'hCAFE_F00D, 4'hF);
        check("oor_count", ld_count_o, 32'd5);

        // Halt beats run while running
        halt_i = 1'b1; run_i = 1'b1;
        step();
        halt_i = 1'b0; run_i = 1'b0;
        check("both_run", 32'(running_o), 32'd0);
        check("both_count", ld_count_o, 32'd0);
        fetch("halt_miss", 32'h0, 1'b0, 32'h1234_5678);

        // Run beats halt while loading
        halt_i = 1'b1; run_i = 1'b1;
        step();
        halt_i = 1'b0; run_i = 1'b0;
        check("both_load", 32'(running_o), 32'd1);

        // Reset with a read in flight discards it
        i_m_rden_i = 1'b1; i_m_addr_i = 32'h4; rst_i = 1'b1;
        step();
        i_m_rden_i = 1'b0; rst_i = 1'b0;
        check("mid_rst_rdata", i_m_rdata_o, NOP);
        check("mid_rst_running", 32'(running_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);

        // Write coinciding with reset is dropped
        ld_valid_i = 1'b1; ld_addr_i = 32'h4; ld_data_i = 32'hAAAA_AAAA; ld_be_i = 4'hF;
        rst_i = 1'b1;
        step();
        ld_valid_i = 1'b0; rst_i = 1'b0;
        check("rst_wr_count", ld_count_o, 32'd0);
        pulse_run();
        fetch("rst_wr_drop", 32'h4, 1'b1, 32'h00A0_0113);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
